// File: rtl/ysyx_22041207_if_axi_master_pkg.sv
// rtl/ysyx_22041207_if_axi_master_pkg.sv - shared types, AXI constants and mask-to-arsize helper
package ysyx_22041207_if_axi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Byte-enable mask to AXI size: only 1/2/4/8 set bits map directly,
  // anything irregular falls back to a full 8-byte beat.
  function automatic logic [2:0] mask_to_arsize(input logic [7:0] mask);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, mask[i]};
    end
    case (ones)
      4'd1:    return 3'd0;
      4'd2:    return 3'd1;
      4'd4:    return 3'd2;
      4'd8:    return 3'd3;
      default: return 3'd3;
    endcase
  endfunction

  // Error responses are SLVERR and DECERR; OKAY/EXOKAY are clean.
  function automatic logic resp_is_error(input logic [1:0] resp);
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:   return 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041207_axi_size_enc.sv
// rtl/ysyx_22041207_axi_size_enc.sv - byte mask to AXI arsize encoder
module ysyx_22041207_axi_size_enc
  import ysyx_22041207_if_axi_master_pkg::*;
(
  input  logic [7:0] mask,
  output logic [2:0] arsize
);

  assign arsize = mask_to_arsize(mask);

endmodule

// File: rtl/ysyx_22041207_if_axi_master.sv
// rtl/ysyx_22041207_if_axi_master.sv - single-outstanding instruction-fetch AXI read master (option: YSYX_22041207_IFAXI_ERR_EN)
module ysyx_22041207_if_axi_master
  import ysyx_22041207_if_axi_master_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int IF_ID = 0
) (
  input  logic            clk,
  input  logic            rst,
  // fetch side
  input  logic            rx_r_valid_i,
  output logic            rx_r_ready_o,
  input  logic [63:0]     rx_r_addr_i,
  input  logic [7:0]      rx_r_size_i,
  output logic [63:0]     rx_data_read_o,
  output logic            rx_data_valid,
  input  logic            rx_data_ready,
  // AR channel
  output logic [63:0]     araddr,
  output logic            arvalid,
  input  logic            arready,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  // R channel
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic [ID_W-1:0] rid,
  input  logic            rvalid,
  output logic            rready
`ifdef YSYX_22041207_IFAXI_ERR_EN
  ,
  output logic            rx_data_err
`endif
);

  localparam logic [ID_W-1:0] FETCH_ID = ID_W'(IF_ID);

  fetch_state_e state_q, state_d;
  logic         ready_en_q;
  logic [63:0]  addr_q;
  logic [7:0]   mask_q;
  logic [63:0]  data_q;
  logic         err_q;
  logic         req_fire;
  logic         beat_ok;

  assign req_fire = rx_r_valid_i && rx_r_ready_o;
  // Single-beat fetch: rlast is implied, and foreign-ID beats are drained.
  assign beat_ok  = rvalid && (rid == FETCH_ID);

  // State register; reset drops straight back to IDLE, abandoning any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Keeps rx_r_ready_o low until the first clock after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  // Latch the request when it is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 64'd0;
      mask_q <= 8'd0;
    end else if (state_q == ST_IDLE && req_fire) begin
      addr_q <= rx_r_addr_i;
      mask_q <= rx_r_size_i;
    end
  end

  // Capture the matching beat, aligned so the addressed byte lands in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 64'd0;
      err_q  <= 1'b0;
    end else if (state_q == ST_DATA && beat_ok) begin
      data_q <= rdata >> {addr_q[2:0], 3'b000};
`ifdef YSYX_22041207_IFAXI_ERR_EN
      err_q  <= resp_is_error(rresp);
`else
      err_q  <= 1'b0;
`endif
    end
  end

  // Next-state and handshake outputs; exactly one handshake is live per state.
  always_comb begin
    state_d       = state_q;
    rx_r_ready_o  = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    rx_data_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rx_r_ready_o = ready_en_q;
        if (req_fire) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        rready = 1'b1;
        if (beat_ok) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        rx_data_valid = 1'b1;
        if (rx_data_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign araddr         = addr_q;
  assign arid           = FETCH_ID;
  assign arlen          = 8'd0;
  assign arburst        = AXI_BURST_INCR;
  assign rx_data_read_o = data_q;

  ysyx_22041207_axi_size_enc u_size_enc (
    .mask   (mask_q),
    .arsize (arsize)
  );

`ifdef YSYX_22041207_IFAXI_ERR_EN
  assign rx_data_err = err_q && (state_q == ST_HOLD);
  logic unused_r;
  assign unused_r = rlast;
`else
  logic unused_r;
  assign unused_r = ^{rlast, resp_is_error(rresp), err_q};
`endif

endmodule

// File: tb/tb_ysyx_22041207_if_axi_master.sv
// tb/tb_ysyx_22041207_if_axi_master.sv - self-checking bench for the fetch AXI master (option: YSYX_22041207_IFAXI_ERR_EN)
module tb_ysyx_22041207_if_axi_master;

  localparam int ID_W  = 4;
  localparam int IF_ID = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_r_valid_i;
  logic            rx_r_ready_o;
  logic [63:0]     rx_r_addr_i;
  logic [7:0]      rx_r_size_i;
  logic [63:0]     rx_data_read_o;
  logic            rx_data_valid;
  logic            rx_data_ready;
  logic [63:0]     araddr;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;
  logic            rvalid;
  logic            rready;
`ifdef YSYX_22041207_IFAXI_ERR_EN
  logic            rx_data_err;
`endif

  ysyx_22041207_if_axi_master #(.ID_W(ID_W), .IF_ID(IF_ID)) dut (
    .clk(clk), .rst(rst),
    .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o),
    .rx_r_addr_i(rx_r_addr_i), .rx_r_size_i(rx_r_size_i),
    .rx_data_read_o(rx_data_read_o), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .rvalid(rvalid), .rready(rready)
`ifdef YSYX_22041207_IFAXI_ERR_EN
    , .rx_data_err(rx_data_err)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int since_rst = 0;
  int ar_hs = 0;
  int req_cyc_g = 0;
  logic last_err = 1'b0;

  // model of the transaction in flight
  logic [63:0] m_addr = '0;
  logic [2:0]  m_size = '0;
  logic [63:0] m_data = '0;
  logic        m_err  = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    since_rst <= rst ? 0 : since_rst + 1;
    if (!rst && arvalid && arready) ar_hs <= ar_hs + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [2:0] model_size(input logic [7:0] m);
    case ($countones(m))
      1:       return 3'd0;
      2:       return 3'd1;
      4:       return 3'd2;
      8:       return 3'd3;
      default: return 3'd3;
    endcase
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_arvalid", 64'(arvalid), 64'd0);
      check("rst_rready", 64'(rready), 64'd0);
      check("rst_data_valid", 64'(rx_data_valid), 64'd0);
      check("rst_r_ready", 64'(rx_r_ready_o), 64'd0);
      check("rst_araddr", araddr, 64'd0);
      check("rst_data", rx_data_read_o, 64'd0);
    end else begin
      check("one_handshake", 64'($countones({rx_r_ready_o, arvalid, rready, rx_data_valid})),
            (since_rst >= 1) ? 64'd1 : 64'd0);
      if (arvalid) begin
        check("araddr", araddr, m_addr);
        check("arsize", 64'(arsize), 64'(m_size));
        check("arlen", 64'(arlen), 64'd0);
        check("arburst", 64'(arburst), 64'd1);
        check("arid", 64'(arid), 64'(IF_ID));
      end
      if (rx_data_valid) check("rx_data", rx_data_read_o, m_data);
`ifdef YSYX_22041207_IFAXI_ERR_EN
      check("rx_data_err", 64'(rx_data_err), rx_data_valid ? 64'(m_err) : 64'd0);
`endif
    end
  end

  task automatic fetch(input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data,
                       input logic [1:0] resp, input int ar_wait, input bit bad_beat,
                       input int cons_wait, input bit pulse_hold,
                       output logic [63:0] got, output logic [2:0] sz, output int lat);
    int t;
    int req_cyc;
    got = '0; sz = '0; lat = -1;
    t = 0;
    while (!rx_r_ready_o && t < 50) begin @(posedge clk); #1; t++; end
    if (!rx_r_ready_o) begin timeout("req_ready"); return; end
    m_addr = addr;
    m_size = model_size(mask);
    m_data = data >> (8 * int'(addr[2:0]));
    m_err  = (resp == 2'b10) || (resp == 2'b11);
    rx_r_valid_i = 1'b1; rx_r_addr_i = addr; rx_r_size_i = mask;
    req_cyc = cyc;
    req_cyc_g = cyc;
    @(posedge clk); #1;
    rx_r_valid_i = 1'b0; rx_r_addr_i = ~addr; rx_r_size_i = ~mask;
    sz = arsize;
    repeat (ar_wait) begin @(posedge clk); #1; end
    arready = 1'b1;
    t = 0;
    while (!arvalid && t < 50) begin @(posedge clk); #1; t++; end
    if (!arvalid) begin timeout("arvalid"); arready = 1'b0; return; end
    @(posedge clk); #1;
    arready = 1'b0;
    if (bad_beat) begin
      rvalid = 1'b1; rid = ID_W'(IF_ID + 1); rdata = ~data; rresp = 2'b10; rlast = 1'b1;
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rid = ID_W'(IF_ID); rdata = data; rresp = resp; rlast = 1'b1;
    t = 0;
    while (!rready && t < 50) begin @(posedge clk); #1; t++; end
    if (!rready) begin timeout("rready"); rvalid = 1'b0; return; end
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    t = 0;
    while (!rx_data_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (!rx_data_valid) begin timeout("rx_data_valid"); return; end
    lat = cyc - req_cyc;
    got = rx_data_read_o;
`ifdef YSYX_22041207_IFAXI_ERR_EN
    last_err = rx_data_err;
`endif
    for (int i = 0; i < cons_wait; i++) begin
      if (pulse_hold) begin
        rx_r_valid_i = (i % 2 == 0);
        rx_r_addr_i  = 64'h9000_0000;
        rx_r_size_i  = 8'h01;
      end
      @(posedge clk); #1;
      check("hold_stable", rx_data_read_o, got);
    end
    rx_r_valid_i = 1'b0;
    rx_data_ready = 1'b1;
    @(posedge clk); #1;
    rx_data_ready = 1'b0;
  endtask

  logic [63:0] got;
  logic [2:0]  sz;
  int          lat;
  int          hs0;
  int          prev_req;

  initial begin
    rst = 1'b1;
    rx_r_valid_i = 0; rx_r_addr_i = '0; rx_r_size_i = '0; rx_data_ready = 0;
    arready = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0; rvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst_same_cycle", 64'(rx_r_ready_o), 64'd0);
    @(posedge clk); #1;
    check("ready_first_cycle", 64'(rx_r_ready_o), 64'd1);

    // basic aligned word fetch, zero wait
    hs0 = ar_hs;
    fetch(64'h8000_0000, 8'h0F, 64'h1111_2222_0000_0013, 2'b00, 0, 0, 0, 0, got, sz, lat);
    check("v1_data", got, 64'h1111_2222_0000_0013);
    check("v1_size", 64'(sz), 64'd2);
    check("v1_latency", 64'(lat), 64'd3);
    check("v1_ar_hs", 64'(ar_hs - hs0), 64'd1);

    // upper word shifted down
    prev_req = req_cyc_g;
    fetch(64'h8000_0004, 8'h0F, 64'hDEAD_BEEF_0000_0000, 2'b00, 0, 0, 0, 0, got, sz, lat);
    check("v2_data", got, 64'h0000_0000_DEAD_BEEF);
    check("v2_spacing", 64'(req_cyc_g - prev_req), 64'd4);

    // arready stalled for 5 cycles
    hs0 = ar_hs;
    fetch(64'h8000_1003, 8'h01, 64'h0123_4567_89AB_CDEF, 2'b00, 5, 0, 0, 0, got, sz, lat);
    check("v3_data", got, 64'h0000_0001_2345_6789);
    check("v3_size", 64'(sz), 64'd0);
    check("v3_ar_hs", 64'(ar_hs - hs0), 64'd1);
    check("v3_latency", 64'(lat), 64'd8);

    // foreign-ID beat before the real one
    fetch(64'h8000_0002, 8'h03, 64'hCAFE_F00D_1234_5678, 2'b00, 0, 1, 0, 0, got, sz, lat);
    check("v4_data", got, 64'h0000_CAFE_F00D_1234);
    check("v4_size", 64'(sz), 64'd1);

    // slow consumer with request pulses during HOLD
    hs0 = ar_hs;
    fetch(64'h8000_0008, 8'hFF, 64'h0011_2233_4455_6677, 2'b00, 0, 0, 4, 1, got, sz, lat);
    check("v5_data", got, 64'h0011_2233_4455_6677);
    check("v5_size", 64'(sz), 64'd3);
    repeat (3) begin
      check("v5_no_ar_after_pulse", 64'(arvalid), 64'd0);
      @(posedge clk); #1;
    end
    check("v5_ar_hs", 64'(ar_hs - hs0), 64'd1);

    // irregular masks
    fetch(64'h8000_0010, 8'h00, 64'h1, 2'b00, 0, 0, 0, 0, got, sz, lat);
    check("v6_size_zero_mask", 64'(sz), 64'd3);
    fetch(64'h8000_0010, 8'h07, 64'h2, 2'b00, 0, 0, 0, 0, got, sz, lat);
    check("v7_size_three_bits", 64'(sz), 64'd3);
    fetch(64'h8000_0010, 8'h05, 64'h3, 2'b00, 0, 0, 0, 0, got, sz, lat);
    check("v8_size_sparse_pair", 64'(sz), 64'd1);

    // reset while waiting for the R beat
    m_addr = 64'h8000_0020; m_size = model_size(8'h0F); m_data = '0; m_err = 1'b0;
    rx_r_valid_i = 1'b1; rx_r_addr_i = 64'h8000_0020; rx_r_size_i = 8'h0F;
    @(posedge clk); #1;
    rx_r_valid_i = 1'b0; arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    check("rst_pre_rready", 64'(rready), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_now_rready", 64'(rready), 64'd0);
    check("rst_now_arvalid", 64'(arvalid), 64'd0);
    check("rst_now_r_ready", 64'(rx_r_ready_o), 64'd0);
    check("rst_now_araddr", araddr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_rel_ready_low", 64'(rx_r_ready_o), 64'd0);
    @(posedge clk); #1;
    check("rst_rel_ready_high", 64'(rx_r_ready_o), 64'd1);

    // recovery fetch carrying SLVERR
    fetch(64'h8000_0001, 8'h01, 64'h0000_0000_0000_AB00, 2'b10, 0, 0, 0, 0, got, sz, lat);
    check("v9_data", got, 64'h0000_0000_0000_00AB);
    check("v9_latency", 64'(lat), 64'd3);
`ifdef YSYX_22041207_IFAXI_ERR_EN
    check("v9_err", 64'(last_err), 64'd1);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
